// File: rtl/regfile_wb_if.sv
// regfile_wb_if: operand-read, write-back, load-issue and trace signals of the register file
// master: decode/write-back side; drives read indices, write-back request and load issue
// slave: register file; returns operands, Stall and the registered write-back trace
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Read_register1;
  logic [ADDR_W-1:0] Read_register2;
  logic [DATA_W-1:0] Read_data1;
  logic [DATA_W-1:0] Read_data2;
  logic              RegWrite;
  logic              MemtoReg;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] ALU_Result;
  logic              Load_issue;
  logic [ADDR_W-1:0] Load_register;
  logic              Stall;
  logic              Wb_valid;
  logic [ADDR_W-1:0] Wb_register;
  logic [DATA_W-1:0] Wb_data;
  modport master (
    output Read_register1, Read_register2, RegWrite, MemtoReg, Write_register,
           data, ALU_Result, Load_issue, Load_register,
    input  Read_data1, Read_data2, Stall, Wb_valid, Wb_register, Wb_data
  );
  modport slave (
    input  Read_register1, Read_register2, RegWrite, MemtoReg, Write_register,
           data, ALU_Result, Load_issue, Load_register,
    output Read_data1, Read_data2, Stall, Wb_valid, Wb_register, Wb_data
  );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: register file with write-back select, write-to-read bypass and load scoreboard
// clk: rising-edge clock; rst_n: asynchronous active-low reset
// rf (slave): two combinational read ports, one write-back per cycle, load issue,
//             Stall when a read operand waits on an outstanding load, registered write trace
module regfile_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_wb_if.slave rf
);
  localparam int NREGS = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_register_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en, ld_en, byp1, byp2, s1, s2;
  assign wr_data = rf.MemtoReg ? rf.data : rf.ALU_Result;
  assign wr_en   = rf.RegWrite && !(ZERO_REG != 0 && rf.Write_register == '0);
  assign ld_en   = rf.Load_issue && !(ZERO_REG != 0 && rf.Load_register == '0);
  assign byp1    = BYPASS != 0 && wr_en && rf.Write_register == rf.Read_register1;
  assign byp2    = BYPASS != 0 && wr_en && rf.Write_register == rf.Read_register2;
  assign rf.Read_data1 = (ZERO_REG != 0 && rf.Read_register1 == '0) ? '0 :
                         byp1 ? wr_data : regs_q[rf.Read_register1];
  assign rf.Read_data2 = (ZERO_REG != 0 && rf.Read_register2 == '0) ? '0 :
                         byp2 ? wr_data : regs_q[rf.Read_register2];
  // a load being satisfied by a memory write-back this cycle no longer holds decode
  assign s1 = pending_q[rf.Read_register1] && !(byp1 && rf.MemtoReg);
  assign s2 = pending_q[rf.Read_register2] && !(byp2 && rf.MemtoReg);
  assign rf.Stall       = s1 | s2;
  assign rf.Wb_valid    = wb_valid_q;
  assign rf.Wb_register = wb_register_q;
  assign rf.Wb_data     = wb_data_q;
  // clear before set so a new load to the same index stays outstanding
  always_comb begin
    pending_d = pending_q;
    if (wr_en && rf.MemtoReg) pending_d[rf.Write_register] = 1'b0;
    if (ld_en) pending_d[rf.Load_register] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_register_q <= '0;
      wb_data_q     <= '0;
    end else begin
      if (wr_en) begin
        regs_q[rf.Write_register] <= wr_data;
        wb_register_q             <= rf.Write_register;
        wb_data_q                 <= wr_data;
      end
      pending_q  <= pending_d;
      wb_valid_q <= wr_en;
    end
  end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed checks of regfile_wb with bypass/zero-reg (a) and without (b)
module tb_regfile_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [4:0]  rr1 = '0, rr2 = '0, wa = '0, lr = '0;
  logic        rw = 1'b0, m2r = 1'b0, li = 1'b0;
  logic [31:0] dat = '0, alu = '0;
  int total = 0;
  int bad = 0;
  typedef struct {logic [4:0] r; logic [31:0] d;} wbe_t;
  wbe_t qa[$];
  wbe_t qb[$];
  wbe_t e;
  regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) ib ();
  assign ia.Read_register1 = rr1;
  assign ia.Read_register2 = rr2;
  assign ia.RegWrite       = rw;
  assign ia.MemtoReg       = m2r;
  assign ia.Write_register = wa;
  assign ia.data           = dat;
  assign ia.ALU_Result     = alu;
  assign ia.Load_issue     = li;
  assign ia.Load_register  = lr;
  assign ib.Read_register1 = rr1;
  assign ib.Read_register2 = rr2;
  assign ib.RegWrite       = rw;
  assign ib.MemtoReg       = m2r;
  assign ib.Write_register = wa;
  assign ib.data           = dat;
  assign ib.ALU_Result     = alu;
  assign ib.Load_issue     = li;
  assign ib.Load_register  = lr;
  regfile_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rf(ia.slave));
  regfile_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rf(ib.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // drive one write-back for this cycle and record the trace each variant should commit
  task automatic wr(input logic [4:0] r, input logic mem, input logic [31:0] v);
    rw = 1'b1; m2r = mem; wa = r;
    if (mem) dat = v; else alu = v;
    if (r != 0) qa.push_back('{r, v});
    qb.push_back('{r, v});
  endtask
  task automatic ld(input logic [4:0] r);
    li = 1'b1; lr = r;
  endtask
  // advance past one edge, compare the write-back trace against the scoreboard, go idle
  task automatic step();
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_wb_valid", ia.Wb_valid, 1);
      chk("a_wb_reg", ia.Wb_register, e.r);
      chk("a_wb_data", ia.Wb_data, e.d);
    end else chk("a_wb_idle", ia.Wb_valid, 0);
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_wb_valid", ib.Wb_valid, 1);
      chk("b_wb_reg", ib.Wb_register, e.r);
      chk("b_wb_data", ib.Wb_data, e.d);
    end else chk("b_wb_idle", ib.Wb_valid, 0);
    rw = 1'b0; m2r = 1'b0; li = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_rd1", ia.Read_data1, 0);
    chk("rst_stall", ia.Stall, 0);
    chk("rst_wbv", ia.Wb_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(7, 0, 32'h1234);
    step();
    ld(7);
    step();
    rr1 = 7; rr2 = 7;
    #1;
    chk("r7_a", ia.Read_data1, 32'h1234);
    chk("r7_b", ib.Read_data1, 32'h1234);
    chk("r7_stall", ia.Stall, 1);
    wa = 8; alu = 32'h99; rw = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", ia.Read_data1, 0);
    chk("arst_stall", ia.Stall, 0);
    chk("arst_wbv", ia.Wb_valid, 0);
    step();
    rst_n = 1'b1;
    rr1 = 8;
    #1;
    chk("arst_r8", ia.Read_data1, 0);
    wr(3, 0, 32'hDEADBEEF); rr1 = 3;
    #1;
    chk("byp_a", ia.Read_data1, 32'hDEADBEEF);
    chk("nobyp_b", ib.Read_data1, 0);
    step();
    #1;
    chk("post_a", ia.Read_data1, 32'hDEADBEEF);
    chk("post_b", ib.Read_data1, 32'hDEADBEEF);
    wr(0, 0, 32'h55); rr1 = 0;
    #1;
    chk("z0_a_same", ia.Read_data1, 0);
    step();
    #1;
    chk("z0_a", ia.Read_data1, 0);
    chk("z0_b", ib.Read_data1, 32'h55);
    ld(5); rr2 = 5; rr1 = 3;
    #1;
    chk("ld5_issue_cycle", ia.Stall, 0);
    step();
    #1;
    chk("ld5_a", ia.Stall, 1);
    chk("ld5_b", ib.Stall, 1);
    step();
    chk("ld5_hold", ia.Stall, 1);
    wr(5, 0, 32'h33);
    #1;
    chk("alu5_stall", ia.Stall, 1);
    step();
    #1;
    chk("alu5_after", ia.Stall, 1);
    chk("alu5_rd2", ia.Read_data2, 32'h33);
    wr(5, 1, 32'hA5);
    #1;
    chk("mem5_a_stall", ia.Stall, 0);
    chk("mem5_a_rd2", ia.Read_data2, 32'hA5);
    chk("mem5_b_stall", ib.Stall, 1);
    chk("mem5_b_rd2", ib.Read_data2, 32'h33);
    step();
    #1;
    chk("clr5_a", ia.Stall, 0);
    chk("clr5_b", ib.Stall, 0);
    chk("clr5_b_rd2", ib.Read_data2, 32'hA5);
    rr2 = 0; rr1 = 9;
    ld(9); wr(9, 1, 32'h11);
    step();
    #1;
    chk("r9_val", ia.Read_data1, 32'h11);
    chk("r9_a_stall", ia.Stall, 1);
    chk("r9_b_stall", ib.Stall, 1);
    rr1 = 0;
    wr(12, 0, 32'h77);
    ld(0);
    step();
    #1;
    chk("z0_nostall_a", ia.Stall, 0);
    chk("z0_stall_b", ib.Stall, 1);
    ld(4); rr1 = 12; rr2 = 12;
    step();
    #1;
    chk("dual_rd1", ia.Read_data1, 32'h77);
    chk("dual_rd2", ia.Read_data2, 32'h77);
    chk("dual_stall", ia.Stall, 0);
    chk("dual_b_rd2", ib.Read_data2, 32'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Parametrised general-purpose register file with an integrated write-back select, same-cycle write-to-read bypass and a per-register load scoreboard. It sits between the decode/operand stage and the write-back stage of the processor datapath. It supplies two read operands and accepts one write-back per cycle, choosing between memory data and the ALU result. It raises a stall when an operand is still waiting on an outstanding load.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Read_register1, Read_register2  in  ADDR_W  read port indices
- Read_data1, Read_data2  out  DATA_W  read port data (combinational)
- RegWrite  in  1  write-back request this cycle
- MemtoReg  in  1  1 selects data, 0 selects ALU_Result
- Write_register  in  ADDR_W  write-back destination
- data  in  DATA_W  memory load data
- ALU_Result  in  DATA_W  ALU result
- Load_issue  in  1  a load targeting Load_register issues this cycle
- Load_register  in  ADDR_W  load destination
- Stall  out  1  operand pending, decode must hold
- Wb_valid  out  1  registered: a write committed last cycle
- Wb_register  out  ADDR_W  registered index of that write
- Wb_data  out  DATA_W  registered value of that write

## Operation
- Write_data = MemtoReg ? data : ALU_Result.
- A write is effective when RegWrite=1 and not (ZERO_REG=1 and Write_register=0).
- Storage: NREGS x DATA_W. An effective write updates Register[Write_register] at the rising clk edge.
- Read: Read_dataN = Register[Read_registerN].
  - Exceptions: 0 when ZERO_REG=1 and the index is 0.
  - Write_data when BYPASS=1, an effective write is present and Write_register=Read_registerN.
- Scoreboard: pending[NREGS] bits.
  - Set at the edge when Load_issue=1 and Load_register is not the hardwired zero register.
  - Cleared at the edge on an effective write with MemtoReg=1 to that index.
  - Simultaneous set and clear of the same index: set wins, the new load is outstanding.
  - An ALU write (MemtoReg=0) never clears pending.
- Stall = s1 | s2, where sN = pending[Read_registerN] and not (BYPASS=1 and an effective MemtoReg=1 write to Read_registerN this cycle).
  - With ZERO_REG=1, index 0 never stalls.
- Trace: at each edge, Wb_valid <= write effective.
  - Wb_register and Wb_data load only when the write is effective; otherwise they hold.

## Timing
- Reset (rst_n=0, asynchronous, no clock required):
  - all registers 0 and all pending bits 0;
  - Wb_valid=0, Wb_register=0, Wb_data=0;
  - Read_data1/2 therefore read 0 and Stall=0.
- Reset asserted mid-operation discards any in-flight write and all pending bits immediately.
- Read latency is 0 cycles (combinational). Write latency is 1 edge. With BYPASS=0, a read of the written index returns the new value from the cycle after the edge.
- Stall is combinational from the read indices and the current write-back. Decode holds its indices while Stall=1. No other handshake exists.
- Same index on both read ports is legal, and both ports return identical data.
- Load_issue and a write-back to the same index in the same cycle are legal: the write commits and pending becomes 1.
- No index wrap or overflow conditions exist; all indices below NREGS are valid.

## Test plan
- Reset with registers previously written (reg 7 = 0x1234), pulse rst_n low between edges -> immediately Read_data1 for index 7 = 0, Stall=0, Wb_valid=0.
- RegWrite=1, MemtoReg=0, Write_register=3, ALU_Result=0xDEADBEEF, Read_register1=3, BYPASS=1 -> Read_data1=0xDEADBEEF in the same cycle; with BYPASS=0 it reads 0 until after the edge, then 0xDEADBEEF; Wb_valid=1, Wb_register=3 the next cycle.
- ZERO_REG=1, write 0x55 to register 0 -> Read_data for index 0 stays 0 and Wb_valid=0. With ZERO_REG=0 the same write reads back 0x55.
- Load_issue to reg 5, then Read_register2=5 -> Stall=1 on the following cycles.
  - An ALU write to 5 keeps Stall=1.
  - A write with MemtoReg=1 and data=0xA5 -> Stall=0 and Read_data2=0xA5 in that cycle (BYPASS=1); pending clears at the edge.
- Same cycle: Load_issue to 9 and MemtoReg=1 write to 9 with data=0x11 -> Register 9 = 0x11 after the edge, and pending[9]=1 so a read of 9 stalls.
- Both read ports on reg 12 = 0x77, with a pending load on reg 4 that is not read -> Read_data1 = Read_data2 = 0x77 and Stall=0.
